ysyx_22040632_mem_arbiter: RTL

Two-requester memory arbiter sharing the core's single memory port between the IFU (instruction fetch) and the LSU (data load/store). One outstanding transaction at a time. Fixed LSU priority with a bounded-starvation guard for fetch. Registered request side toward memory; the response is routed back to the owner of the in-flight transaction.

---
 rtl/ysyx_22040632_mem_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/ysyx_22040632_mem_arbiter.sv
// ysyx_22040632_mem_arbiter: IFU/LSU arbiter for one memory port, LSU priority with a fetch starvation guard
module ysyx_22040632_mem_arbiter #(
  parameter int unsigned MAX_LSU_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [63:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [63:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        spurious_rsp
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  localparam logic [3:0] MAX = 4'(MAX_LSU_RUN);
  state_e      state_q, state_d;
  logic        owner_lsu_q, owner_lsu_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [7:0]  wmask_q, wmask_d;
  logic        spurious_q, spurious_d;
  logic        idle, ifu_win, ifu_gnt, lsu_gnt, rsp_fire;
  always_comb begin
    idle = state_q == IDLE && !rst;
    ifu_win = !lsu_req_valid || run_cnt_q == MAX;
    ifu_gnt = idle && ifu_req_valid && ifu_win;
    lsu_gnt = idle && lsu_req_valid && !(ifu_req_valid && ifu_win);
    rsp_fire = state_q == RESP && mem_rsp_valid;
    state_d = (ifu_gnt || lsu_gnt) ? REQ :
              (state_q == REQ && mem_req_ready) ? RESP :
              rsp_fire ? IDLE : state_q;
    owner_lsu_d = ifu_gnt ? 1'b0 : lsu_gnt ? 1'b1 : owner_lsu_q;
    addr_d = ifu_gnt ? ifu_addr : lsu_gnt ? lsu_addr : addr_q;
    wdata_d = ifu_gnt ? '0 : lsu_gnt ? lsu_wdata : wdata_q;
    wen_d = ifu_gnt ? 1'b0 : lsu_gnt ? lsu_wen : wen_q;
    wmask_d = ifu_gnt ? '0 : lsu_gnt ? (lsu_wen ? lsu_wmask : '0) : wmask_q;
    // Only LSU wins that keep a fetch waiting count toward the run limit
    run_cnt_d = ifu_gnt ? '0 :
                lsu_gnt ? (ifu_req_valid ? (run_cnt_q >= MAX ? MAX : run_cnt_q + 4'd1) : '0) :
                run_cnt_q;
    spurious_d = spurious_q || (mem_rsp_valid && state_q != RESP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_lsu_q <= 1'b0;
      run_cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
      wmask_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_lsu_q <= owner_lsu_d;
      run_cnt_q <= run_cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wen_q <= wen_d;
      wmask_q <= wmask_d;
      spurious_q <= spurious_d;
    end
  end
  assign ifu_req_ready = ifu_gnt;
  assign lsu_req_ready = lsu_gnt;
  assign ifu_rsp_valid = rsp_fire && !owner_lsu_q;
  assign lsu_rsp_valid = rsp_fire && owner_lsu_q;
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;
  assign mem_req_valid = state_q == REQ;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wen = wen_q;
  assign mem_wmask = wmask_q;
  assign spurious_rsp = spurious_q;
endmodule
